// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one FULL_SUB cell walks WIDTH-bit operands LSB first.
// Optional compare flags (eq/lt) are built when SERIAL_SUB_CMP_EN is defined.

module FULL_SUB (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & (b | bin)) | (b & bin);
endmodule

// state | meaning
// IDLE  | ready for start; operands latched on accepted start
// RUN   | one bit per edge through the cell, borrow chained in brw
// DONE  | done pulse, d/bout valid; returns to IDLE unconditionally
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_CMP_EN
  ,
  output logic             eq,
  output logic             lt
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_sh_nxt;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;

  FULL_SUB u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Shift form keeps the expression legal when WIDTH is 1.
  assign d_sh_nxt = (d_sh >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
      eq    <= 1'b0;
      lt    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            d_sh  <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_sh_nxt;
          brw  <= cell_bout;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            d     <= d_sh_nxt;
            bout  <= cell_bout;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_CMP_EN
            eq    <= (d_sh_nxt == '0) && !cell_bout;
            lt    <= cell_bout;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: WIDTH=8 and WIDTH=1 instances,
// table vectors, random operands vs arithmetic model, start-ignore and reset-abort sequences.

module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8, bin8, ready8, busy8, done8, bout8;
  logic [7:0] a8, b8, d8;
  logic       start1, bin1, ready1, busy1, done1, bout1;
  logic [0:0] a1, b1, d1;
`ifdef SERIAL_SUB_CMP_EN
  logic eq8, lt8, eq1, lt1;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .d(d8), .bout(bout8)
`ifdef SERIAL_SUB_CMP_EN
    , .eq(eq8), .lt(lt8)
`endif
  );

  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .ready(ready1), .busy(busy1), .done(done1), .d(d1), .bout(bout1)
`ifdef SERIAL_SUB_CMP_EN
    , .eq(eq1), .lt(lt1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Run one 8-bit operation and compare with a - b - bin computed arithmetically.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, input string nm);
    int   k;
    int   diff;
    logic [7:0] ed;
    logic eb;
    diff = int'(ta) - int'(tb_) - int'(tbin);
    ed   = diff[7:0];
    eb   = (diff < 0);
    @(negedge clk);
    a8 = ta; b8 = tb_; bin8 = tbin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx; bin8 = 1'bx;
    k = 1;
    chk({nm, "_busy"}, {31'd0, busy8}, 32'd1);
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, 9);
    chk({nm, "_d"}, {24'd0, d8}, {24'd0, ed});
    chk({nm, "_bout"}, {31'd0, bout8}, {31'd0, eb});
`ifdef SERIAL_SUB_CMP_EN
    chk({nm, "_eq"}, {31'd0, eq8}, {31'd0, (ed == 8'd0) && !eb});
    chk({nm, "_lt"}, {31'd0, lt8}, {31'd0, eb});
`endif
    @(negedge clk);
    chk({nm, "_ready_after"}, {30'd0, ready8, done8}, 32'd2);
  endtask

  task automatic op1(input logic ta, input logic tb_, input logic tbin, input string nm);
    int k;
    @(negedge clk);
    a1 = ta; b1 = tb_; bin1 = tbin; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 1;
    while (!done1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, 2);
    chk({nm, "_d"}, {31'd0, d1[0]}, {31'd0, ta ^ tb_ ^ tbin});
    chk({nm, "_bout"}, {31'd0, bout1}, {31'd0, int'(ta) < int'(tb_) + int'(tbin)});
    @(negedge clk);
    chk({nm, "_ready_after"}, {31'd0, ready1}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_d;
    logic       exp_bout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int ndone;
    int dd;
    vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};

    rst = 1'b1; start8 = 0; start1 = 0;
    a8 = 0; b8 = 0; bin8 = 0; a1 = 0; b1 = 0; bin1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {27'd0, ready8, busy8, done8, bout8, ready1}, {27'd0, 5'b10001});
    chk("reset_d", {24'd0, d8}, 32'd0);
    rst = 1'b0;

    // Table vectors: expected values written out by hand.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a8 = vecs[i].a; b8 = vecs[i].b; bin8 = vecs[i].bin; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      k = 1;
      while (!done8 && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("vec%0d_latency", i), k, 9);
      chk($sformatf("vec%0d_d", i), {24'd0, d8}, {24'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_bout", i), {31'd0, bout8}, {31'd0, vecs[i].exp_bout});
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'd0, ready8}, 32'd1);
    end

    for (int i = 0; i < 30; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd%0d", i));

    // start at E3 and during DONE must be ignored.
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    dd = -1;
    for (int n = 1; n <= 16; n++) begin
      if (n == 3) begin a8 = 8'hAA; b8 = 8'h01; bin8 = 1'b1; start8 = 1'b1; end
      if (n == 4) start8 = 1'b0;
      if (done8) begin
        ndone++;
        dd = int'(d8);
        a8 = 8'h77; b8 = 8'h01; start8 = 1'b1;
      end else if (n != 3) begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    chk("ignore_done_count", ndone, 1);
    chk("ignore_d", dd, 32'h23);
    chk("ignore_idle_after", {30'd0, ready8, busy8}, 32'd2);

    // Reset asserted at E4 aborts without a done pulse.
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int n = 1; n < 4; n++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {29'd0, ready8, busy8, done8}, 32'd4);
    chk("abort_d", {23'd0, d8, bout8}, 32'd0);
    for (int n = 0; n < 12; n++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);
    op8(8'h10, 8'h01, 1'b0, "post_abort");

    // rst and start on the same edge: start dropped.
    @(negedge clk);
    rst = 1'b1; a8 = 8'h44; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    chk("rst_start_same_edge", {30'd0, ready8, busy8}, 32'd2);
    @(negedge clk);
    chk("rst_start_stays_idle", {30'd0, ready8, busy8}, 32'd2);

    for (int i = 0; i < 8; i++)
      op1(i[2], i[1], i[0], $sformatf("w1_%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
